// File: rtl/vga_bouncing_box_if.sv
// Pixel-timing inputs and VGA pin outputs of the bouncing-box renderer.
// master = timing/colour source side, slave = renderer side.
`timescale 1ns/1ps
interface vga_bouncing_box_if;
    logic       i_hsync;
    logic       i_vsync;
    logic       i_vblank;
    logic       i_visible;
    logic [9:0] i_hpos;
    logic [9:0] i_vpos;
    logic       i_pause;
    logic [8:0] i_box_color;
    logic [8:0] i_bg_color;
    logic       o_hsync;
    logic       o_vsync;
    logic [2:0] o_red;
    logic [2:0] o_grn;
    logic [2:0] o_blu;
    logic       o_frame_tick;
    logic [9:0] o_box_x;
    logic [9:0] o_box_y;

    modport master (
        output i_hsync, i_vsync, i_vblank, i_visible, i_hpos, i_vpos,
               i_pause, i_box_color, i_bg_color,
        input  o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame_tick,
               o_box_x, o_box_y
    );

    modport slave (
        input  i_hsync, i_vsync, i_vblank, i_visible, i_hpos, i_vpos,
               i_pause, i_box_color, i_bg_color,
        output o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame_tick,
               o_box_x, o_box_y
    );
endinterface

// File: rtl/vga_bouncing_box.sv
// Draws a bouncing square over a background; pixels and syncs 2 cycles after inputs.
// No backpressure: one pixel accepted and produced every clock.
`timescale 1ns/1ps
module vga_bouncing_box #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BOX_SIZE  = 32,
    parameter int BOX_SPEED = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    vga_bouncing_box_if.slave   bus
);
    localparam logic [10:0] SIZE11  = 11'(BOX_SIZE);
    localparam logic [10:0] SPEED11 = 11'(BOX_SPEED);
    localparam logic [9:0]  SPEED10 = 10'(BOX_SPEED);
    localparam logic [10:0] XMAX11  = 11'(H_VISIBLE - BOX_SIZE);
    localparam logic [10:0] YMAX11  = 11'(V_VISIBLE - BOX_SIZE);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;

    state_t     state_q, state_d;
    logic       prev_vblank_q, prev_vblank_d;
    logic       frame_tick_q, frame_tick_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards 0
    logic       s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d;
    logic       s1_visible_q, s1_visible_d, s1_in_box_q, s1_in_box_d;
    logic [8:0] s1_box_color_q, s1_box_color_d, s1_bg_color_q, s1_bg_color_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [8:0] rgb_q, rgb_d;
    logic       vblank_rise;

    // Returns {new_dir, new_pos}; clamps onto the edge and flips in one step.
    function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                              input logic       neg,
                                              input logic [10:0] pmax);
        logic [10:0] p;
        p = {1'b0, pos};
        if (!neg) begin
            if (p + SPEED11 >= pmax) return {1'b1, pmax[9:0]};
            else                     return {1'b0, pos + SPEED10};
        end else begin
            if (p <= SPEED11) return {1'b0, 10'd0};
            else              return {1'b1, pos - SPEED10};
        end
    endfunction

    assign vblank_rise = bus.i_vblank & ~prev_vblank_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vblank_rise && !bus.i_pause) state_d = MOVE_X;
            MOVE_X:  state_d = MOVE_Y;
            MOVE_Y:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d  = x_q;
        dx_d = dx_q;
        y_d  = y_q;
        dy_d = dy_q;
        case (state_q)
            MOVE_X:  {dx_d, x_d} = axis_step(x_q, dx_q, XMAX11);
            MOVE_Y:  {dy_d, y_d} = axis_step(y_q, dy_q, YMAX11);
            default: ;
        endcase
        prev_vblank_d = bus.i_vblank;
        frame_tick_d  = vblank_rise;
    end

    // Colours travel with the pixel so a colour change lands exactly 2 cycles later.
    always_comb begin
        s1_hsync_d     = bus.i_hsync;
        s1_vsync_d     = bus.i_vsync;
        s1_visible_d   = bus.i_visible;
        s1_in_box_d    = ({1'b0, bus.i_hpos} >= {1'b0, x_q}) &&
                         ({1'b0, bus.i_hpos} <  ({1'b0, x_q} + SIZE11)) &&
                         ({1'b0, bus.i_vpos} >= {1'b0, y_q}) &&
                         ({1'b0, bus.i_vpos} <  ({1'b0, y_q} + SIZE11));
        s1_box_color_d = bus.i_box_color;
        s1_bg_color_d  = bus.i_bg_color;
        hsync_d        = s1_hsync_q;
        vsync_d        = s1_vsync_q;
        rgb_d          = 9'd0;
        if (s1_visible_q) rgb_d = s1_in_box_q ? s1_box_color_q : s1_bg_color_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            prev_vblank_q  <= 1'b0;
            frame_tick_q   <= 1'b0;
            x_q            <= 10'd0;
            y_q            <= 10'd0;
            dx_q           <= 1'b0;
            dy_q           <= 1'b0;
            s1_hsync_q     <= 1'b0;
            s1_vsync_q     <= 1'b0;
            s1_visible_q   <= 1'b0;
            s1_in_box_q    <= 1'b0;
            s1_box_color_q <= 9'd0;
            s1_bg_color_q  <= 9'd0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            rgb_q          <= 9'd0;
        end else begin
            state_q        <= state_d;
            prev_vblank_q  <= prev_vblank_d;
            frame_tick_q   <= frame_tick_d;
            x_q            <= x_d;
            y_q            <= y_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            s1_hsync_q     <= s1_hsync_d;
            s1_vsync_q     <= s1_vsync_d;
            s1_visible_q   <= s1_visible_d;
            s1_in_box_q    <= s1_in_box_d;
            s1_box_color_q <= s1_box_color_d;
            s1_bg_color_q  <= s1_bg_color_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            rgb_q          <= rgb_d;
        end
    end

    assign bus.o_hsync      = hsync_q;
    assign bus.o_vsync      = vsync_q;
    assign bus.o_red        = rgb_q[8:6];
    assign bus.o_grn        = rgb_q[5:3];
    assign bus.o_blu        = rgb_q[2:0];
    assign bus.o_frame_tick = frame_tick_q;
    assign bus.o_box_x      = x_q;
    assign bus.o_box_y      = y_q;
endmodule

// File: tb/tb_vga_bouncing_box.sv
// Bench for vga_bouncing_box: directed pixel vectors and frame sequences,
// expectations queued at issue time and compared by a separate monitor.
`timescale 1ns/1ps
module tb_vga_bouncing_box;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_bouncing_box_if vif();
    vga_bouncing_box #(.H_VISIBLE(640), .V_VISIBLE(480), .BOX_SIZE(32), .BOX_SPEED(2))
        dut (.i_clk(clk), .i_rst(rst), .bus(vif.slave));

    typedef struct {
        int          due;
        int          kind;   // 0 pixel, 1 position, 2 frame tick
        int          id;
        logic [19:0] exp;
    } sb_t;
    sb_t sbq[$];

    // Pixel vectors: hsync, vsync, visible, hpos, vpos, box, bg, expected rgb (box at 0,0)
    logic       tv_hs  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tv_vs  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       tv_vis [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] tv_hp  [10] = '{10'd0, 10'd31, 10'd32, 10'd31, 10'd31, 10'd0, 10'd10, 10'd639, 10'd0, 10'd32};
    logic [9:0] tv_vp  [10] = '{10'd0, 10'd0, 10'd0, 10'd31, 10'd32, 10'd0, 10'd10, 10'd479, 10'd31, 10'd32};
    logic [8:0] tv_box [10] = '{9'h1C0, 9'h1C0, 9'h1C0, 9'h0A5, 9'h0A5, 9'h1C0, 9'h1FF, 9'h1FF, 9'h1C0, 9'h1C0};
    logic [8:0] tv_bg  [10] = '{9'h007, 9'h007, 9'h007, 9'h111, 9'h111, 9'h007, 9'h1FF, 9'h038, 9'h007, 9'h007};
    logic [8:0] tv_exp [10] = '{9'h1C0, 9'h1C0, 9'h007, 9'h0A5, 9'h111, 9'h000, 9'h000, 9'h038, 9'h1C0, 9'h007};

    // Hand-computed box position after frame n (speed 2, box 32, 640x480)
    int ck_n [13] = '{1, 223, 224, 225, 303, 304, 305, 447, 448, 449, 607, 608, 609};
    int ck_x [13] = '{2, 446, 448, 450, 606, 608, 606, 322, 320, 318, 2, 0, 2};
    int ck_y [13] = '{2, 446, 448, 446, 290, 288, 286, 2, 0, 2, 318, 320, 322};

    function automatic string kname(input int k);
        if (k == 0) return "pixel";
        if (k == 1) return "pos";
        return "tick";
    endfunction

    function automatic logic [19:0] actual(input int k);
        if (k == 0) return {9'd0, vif.o_hsync, vif.o_vsync, vif.o_red, vif.o_grn, vif.o_blu};
        if (k == 1) return {vif.o_box_x, vif.o_box_y};
        return {19'd0, vif.o_frame_tick};
    endfunction

    task automatic check(input string nm, input int id, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s id=%0d cyc=%0d got=%h want=%h", nm, id, cyc, act, exp);
        end
    endtask

    task automatic push(input int due, input int kind, input int id, input logic [19:0] exp);
        sb_t e;
        e.due = due; e.kind = kind; e.id = id; e.exp = exp;
        sbq.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s id=%0d missed due=%0d cyc=%0d", kname(sbq[i].kind), sbq[i].id, sbq[i].due, cyc);
                sbq.delete(i);
            end else if (sbq[i].due == cyc) begin
                check(kname(sbq[i].kind), sbq[i].id, actual(sbq[i].kind), sbq[i].exp);
                sbq.delete(i);
            end
        end
    end

    task automatic pix_at(input int i, input int id);
        vif.i_hsync     = tv_hs[i];
        vif.i_vsync     = tv_vs[i];
        vif.i_visible   = tv_vis[i];
        vif.i_hpos      = tv_hp[i];
        vif.i_vpos      = tv_vp[i];
        vif.i_box_color = tv_box[i];
        vif.i_bg_color  = tv_bg[i];
        push(cyc + 2, 0, id, {9'd0, tv_hs[i], tv_vs[i], tv_exp[i]});
    endtask

    task automatic frame(input int n, input bit chk, input int ex, input int ey, input bit pause_mid);
        @(negedge clk);
        vif.i_vblank = 1'b1;
        push(cyc + 1, 2, n, 20'd1);
        push(cyc + 2, 2, n, 20'd0);
        if (chk) push(cyc + 3, 1, n, {10'(ex), 10'(ey)});
        @(negedge clk);
        if (pause_mid) vif.i_pause = 1'b1;
        repeat (2) @(negedge clk);
        vif.i_vblank = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
    endtask

    initial begin
        bit chk;
        int ex, ey;
        vif.i_hsync = 1'b0; vif.i_vsync = 1'b0; vif.i_vblank = 1'b0; vif.i_visible = 1'b0;
        vif.i_hpos = 10'd0; vif.i_vpos = 10'd0; vif.i_pause = 1'b0;
        vif.i_box_color = 9'd0; vif.i_bg_color = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_pix", 0, actual(0), 20'd0);
        check("rst_pos", 0, actual(1), 20'd0);
        check("rst_tick", 0, actual(2), 20'd0);

        // Release and stream pixel vectors back to back
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                rst = 1'b0;
                push(cyc + 1, 0, 100, 20'd0);
            end else begin
                @(negedge clk);
            end
            pix_at(i, i);
        end
        @(negedge clk);
        vif.i_visible = 1'b0; vif.i_hsync = 1'b0; vif.i_vsync = 1'b0;
        drain();

        // Motion: bounces at right, bottom, top and left edges
        for (int n = 1; n <= 609; n++) begin
            chk = 1'b0; ex = 0; ey = 0;
            for (int c = 0; c < 13; c++) begin
                if (ck_n[c] == n) begin
                    chk = 1'b1; ex = ck_x[c]; ey = ck_y[c];
                end
            end
            frame(n, chk, ex, ey, 1'b0);
        end

        // Pause raised mid-update still completes it; then three frozen frames
        frame(700, 1'b1, 4, 324, 1'b1);
        for (int p = 0; p < 3; p++) frame(701 + p, 1'b1, 4, 324, 1'b0);
        vif.i_pause = 1'b0;
        frame(704, 1'b1, 6, 326, 1'b0);
        drain();

        // Async reset mid-frame
        @(negedge clk);
        vif.i_hsync = 1'b1; vif.i_vsync = 1'b1; vif.i_visible = 1'b1;
        vif.i_hpos = 10'd300; vif.i_vpos = 10'd200;
        vif.i_box_color = 9'h1C0; vif.i_bg_color = 9'h1FF;
        push(cyc + 2, 0, 200, {9'd0, 1'b1, 1'b1, 9'h1FF});
        push(cyc + 1, 1, 200, {10'd6, 10'd326});
        drain();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_pix", 201, actual(0), 20'd0);
        check("arst_pos", 201, actual(1), 20'd0);
        check("arst_tick", 201, actual(2), 20'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(cyc + 1, 0, 202, 20'd0);
        push(cyc + 1, 1, 202, 20'd0);
        pix_at(0, 203);
        @(negedge clk);
        pix_at(2, 204);
        @(negedge clk);
        vif.i_visible = 1'b0;
        drain();

        while (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s id=%0d never compared", kname(sbq[0].kind), sbq[0].id);
            void'(sbq.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_bouncing_box.md
Name: vga_bouncing_box

Overview:
Pixel-rendering stage directly downstream of the video sync generator. Consumes per-pixel timing (syncs, blanks, visible, hpos/vpos) and draws a solid square on a solid background. The square bounces off the visible-area edges and moves once per frame during vertical blanking. Drives the 3-bit-per-channel VGA pins, with syncs re-delayed so they stay aligned with the pixel data.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
BOX_SIZE, 32, square edge length in pixels
BOX_SPEED, 2, pixels moved per axis per frame; BOX_SIZE+BOX_SPEED must be < min(H_VISIBLE, V_VISIBLE)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  reset, asynchronous, active-high
i_hsync  in  1  horizontal sync from the sync generator
i_vsync  in  1  vertical sync from the sync generator
i_vblank  in  1  high outside visible lines
i_visible  in  1  high inside the visible area
i_hpos  in  10  current pixel column
i_vpos  in  10  current line
i_pause  in  1  level; high freezes box motion
i_box_color  in  9  {R[2:0],G[2:0],B[2:0]} square colour
i_bg_color  in  9  {R,G,B} background colour
o_hsync  out  1  i_hsync delayed 2 cycles
o_vsync  out  1  i_vsync delayed 2 cycles
o_red  out  3  red pixel
o_grn  out  3  green pixel
o_blu  out  3  blue pixel
o_frame_tick  out  1  one-cycle pulse per frame
o_box_x  out  10  current square left column (debug)
o_box_y  out  10  current square top line (debug)

Behaviour:
Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.

Reset values (applied immediately, including mid-frame):
- All outputs 0.
- Pipelines cleared.
- x=0, y=0, dx=+, dy=+.
- FSM in IDLE.
- Previous-vblank register = 0.

Pixel pipeline, fixed latency 2 cycles from inputs to all of o_hsync/o_vsync/o_red/o_grn/o_blu:
- Stage 1 registers:
  - hsync, vsync, visible.
  - in_box = (hpos >= x) & (hpos < x+BOX_SIZE) & (vpos >= y) & (vpos < y+BOX_SIZE).
  - Comparisons use 11-bit sums so there is no wrap.
- Stage 2 registers:
  - sync outputs from stage 1.
  - colour = visible ? (in_box ? i_box_color : i_bg_color) : 0.
- RGB is forced to 0 whenever stage-1 visible is low.
- Sync polarity passes through unchanged.

Frame event:
- vblank_rise = i_vblank & ~prev_vblank.
- o_frame_tick is asserted the cycle after vblank_rise, for exactly 1 cycle, regardless of i_pause.

Motion FSM (states IDLE, MOVE_X, MOVE_Y):
- IDLE → MOVE_X on vblank_rise when i_pause=0. Otherwise stay in IDLE.
- MOVE_X → MOVE_Y unconditionally. Updates x only.
- MOVE_Y → IDLE unconditionally. Updates y only.
- A vblank_rise while not in IDLE is ignored. Unreachable with legal timing, but required.
- x/y change only during vblank, so there is no tearing.

Axis update, shown for X with XMAX = H_VISIBLE-BOX_SIZE. Y is identical with YMAX = V_VISIBLE-BOX_SIZE.
- dx=+ and x+BOX_SPEED >= XMAX: x <= XMAX, dx <= −.
- dx=+ otherwise: x <= x+BOX_SPEED.
- dx=− and x <= BOX_SPEED: x <= 0, dx <= +.
- dx=− otherwise: x <= x−BOX_SPEED.
- Direction flips in the same cycle as the clamp. The following frame moves away from the edge.

Pause behaviour:
- i_pause is sampled only on vblank_rise.
- Asserting it mid-update does not abort MOVE_Y.

Colour inputs: sampled every cycle, with no internal latching; changes take effect 2 cycles later.

Test Plan:
1. Reset alignment: release reset; drive visible=1, hpos=0, vpos=0, box=9'h1C0, bg=9'h007 → o_red=7, o_grn=0, o_blu=0 exactly 2 cycles later. o_hsync/o_vsync track inputs with a 2-cycle delay across a full line toggle.
2. Blanking: visible=0, hpos=0, vpos=0 → RGB=0 after 2 cycles while o_hsync follows i_hsync delayed 2. hpos=31 is in_box and hpos=32 is background, when x=0 and visible=1.
3. Right bounce: preset via frames to x=606, dx=+; one vblank rise → x=608, dx=−. Next frame → x=606.
4. Left/top bounce: x=1, dx=− → x=0, dx=+. Independently, y=447, dy=+ → y=448 (YMAX), dy=−.
5. Pause: i_pause=1 across 3 frames → x/y unchanged and o_frame_tick pulses 3 times, each 1 cycle wide. Deassert → the next frame advances by 2.
6. Async reset mid-frame at hpos=300, vpos=200 with the box moved → outputs 0 in the same cycle with no clock edge. After release, x=y=0 and the first output arrives with 2-cycle latency.
